// File: rtl/odd_even_merge_if.sv
// Odd/even shunt bus between transmitter (master) and receive merge (slave).
// Carries the two digit buses, the phase select and the receiver status.
interface odd_even_merge_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0] i_odd;
  logic [WIDTH-1:0] i_even;
  logic             i_dclk;
  logic [WIDTH-1:0] o_data_out;
  logic             o_data_vld;
  logic             o_locked;
  logic [1:0]       o_state;
  logic             o_seq_err;
  logic [ERR_W-1:0] o_err_cnt;
  logic             o_phase_err;

  modport master (
    output i_odd, i_even, i_dclk,
    input  o_data_out, o_data_vld, o_locked, o_state, o_seq_err, o_err_cnt, o_phase_err
  );

  modport slave (
    input  i_odd, i_even, i_dclk,
    output o_data_out, o_data_vld, o_locked, o_state, o_seq_err, o_err_cnt, o_phase_err
  );
endinterface

// File: rtl/odd_even_merge.sv
// Receive merge of the odd/even shunt: locks onto the 9..1,15 countdown and forwards digits.
// Optional dclk phase checking is enabled by defining ODD_EVEN_PHASE_CHECK_EN.
module odd_even_merge #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  odd_even_merge_if.slave  bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(MISS_MAX + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_cap;
  logic             r_cap_vld;
  logic [WIDTH-1:0] r_expected;
  logic [MW-1:0]    r_match_cnt;
  logic [SW-1:0]    r_miss_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_vld;
  logic             r_locked;
  logic             r_seq_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic             w_cap_bad;
  logic             w_match;
  logic [MW-1:0]    w_match_inc;
  logic [SW-1:0]    w_miss_inc;

  function automatic logic [WIDTH-1:0] next_digit(input logic [WIDTH-1:0] v);
    if ((v >= WIDTH'(2)) && (v <= WIDTH'(9))) return v - 1'b1;
    if (v == WIDTH'(1))                       return WIDTH'(15);
    return WIDTH'(9);
  endfunction

`ifdef ODD_EVEN_PHASE_CHECK_EN
  logic r_dclk_prev;
  logic r_cap_bad;
  logic r_phase_err;

  // A repeated dclk level means the transmitter skipped a phase; the sample is untrusted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dclk_prev <= 1'b0;
      r_cap_bad   <= 1'b0;
      r_phase_err <= 1'b0;
    end else begin
      r_dclk_prev <= bus.i_dclk;
      r_cap_bad   <= r_cap_vld && (bus.i_dclk == r_dclk_prev);
      r_phase_err <= r_cap_vld && r_cap_bad;
    end
  end

  assign w_cap_bad       = r_cap_bad;
  assign bus.o_phase_err = r_phase_err;
`else
  assign w_cap_bad       = 1'b0;
  assign bus.o_phase_err = 1'b0;
`endif

  assign w_match     = !w_cap_bad && (r_cap == r_expected);
  assign w_match_inc = r_match_cnt + 1'b1;
  assign w_miss_inc  = r_miss_cnt + 1'b1;

  // NOTE: every flop here uses <= so the capture and evaluate stages see last cycle's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_cap       <= '0;
      r_cap_vld   <= 1'b0;
      r_expected  <= WIDTH'(9);
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_data_out  <= '0;
      r_data_vld  <= 1'b0;
      r_locked    <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      // Only the active bus is sampled, so the idle bus never reaches r_cap.
      r_cap      <= bus.i_dclk ? bus.i_even : bus.i_odd;
      r_cap_vld  <= 1'b1;
      r_data_vld <= 1'b0;
      r_seq_err  <= 1'b0;

      if (r_cap_vld) begin
        case (r_state)
          HUNT: begin
            if (!w_cap_bad && (r_cap == WIDTH'(9))) begin
              r_state     <= SYNC;
              r_match_cnt <= MW'(1);
              r_expected  <= WIDTH'(8);
            end
          end

          SYNC: begin
            if (w_match) begin
              r_match_cnt <= w_match_inc;
              r_expected  <= next_digit(r_cap);
              if (w_match_inc == MW'(LOCK_CNT)) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end
            end else if (!w_cap_bad && (r_cap == WIDTH'(9))) begin
              r_match_cnt <= MW'(1);
              r_expected  <= WIDTH'(8);
            end else begin
              r_state     <= HUNT;
              r_match_cnt <= '0;
            end
          end

          LOCKED: begin
            if (w_match) begin
              r_data_out <= r_cap;
              r_data_vld <= 1'b1;
              r_miss_cnt <= '0;
              r_expected <= next_digit(r_cap);
            end else begin
              // Flywheel: keep counting down as if the expected digit had arrived.
              r_seq_err  <= 1'b1;
              r_expected <= next_digit(r_expected);
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
              if (w_miss_inc == SW'(MISS_MAX)) begin
                r_state     <= HUNT;
                r_locked    <= 1'b0;
                r_miss_cnt  <= '0;
                r_match_cnt <= '0;
              end else begin
                r_miss_cnt <= w_miss_inc;
              end
            end
          end

          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_data_out = r_data_out;
  assign bus.o_data_vld = r_data_vld;
  assign bus.o_locked   = r_locked;
  assign bus.o_state    = r_state;
  assign bus.o_seq_err  = r_seq_err;
  assign bus.o_err_cnt  = r_err_cnt;

endmodule
